// File: rtl/int_to_float_seq.sv
// Sequential integer to floating-point converter: accept, normalise one bit per
// cycle, round half-up on a single guard bit, saturate the exponent, then hold.
module int_to_float_seq #(
  parameter int IN_W   = 12,
  parameter int EXP_W  = 3,
  parameter int MAN_W  = 4,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             S,
  output logic [EXP_W-1:0] E,
  output logic [MAN_W-1:0] F
);

  // Two spare bits: the counter must reach E_MAX+1 and then take a rounding carry.
  localparam int CNT_W = EXP_W + 2;
  localparam logic [CNT_W-1:0] E_MAX  = CNT_W'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0] E_INIT = CNT_W'(IN_W - MAN_W);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [IN_W-1:0]          r_sh;
  logic [CNT_W-1:0]         r_e;
  logic                     r_sign;
  logic                     r_out_valid;
  logic                     r_s;
  logic [EXP_W-1:0]         r_eo;
  logic [MAN_W-1:0]         r_f;

  logic                     w_accept;
  logic                     w_neg;
  logic                     w_norm_done;
  logic [IN_W-1:0]          w_mag;
  logic [MAN_W:0]           w_rnd;
  logic [CNT_W-1:0]         w_e_rnd;
  logic [EXP_W+MAN_W-1:0]   w_sat;

  // Returns {carry, mantissa}; on carry the mantissa renormalises to 100..0.
  function automatic logic [MAN_W:0] round_half_up(input logic [MAN_W-1:0] m,
                                                   input logic g);
    logic [MAN_W:0] sum;
    sum = {1'b0, m} + {{MAN_W{1'b0}}, g};
    if (sum[MAN_W])
      sum = {1'b1, MAN_W'(1) << (MAN_W - 1)};
    return sum;
  endfunction

  function automatic logic [EXP_W+MAN_W-1:0] saturate(input logic [CNT_W-1:0] e,
                                                      input logic [MAN_W-1:0] m);
    if (e > E_MAX)
      return {{EXP_W{1'b1}}, {MAN_W{1'b1}}};
    return {e[EXP_W-1:0], m};
  endfunction

  assign in_ready    = (r_state == IDLE) & ~rst;
  assign w_accept    = in_valid & in_ready;
  assign w_neg       = (SIGNED != 0) && D[IN_W-1];
  // The most negative input negates to 100..0, which is its correct magnitude.
  assign w_mag       = w_neg ? (~D + IN_W'(1)) : D;
  assign w_norm_done = r_sh[IN_W-1] | (r_e == '0);
  assign w_rnd       = round_half_up(r_sh[IN_W-1 -: MAN_W], r_sh[IN_W-MAN_W-1]);
  assign w_e_rnd     = r_e + CNT_W'(w_rnd[MAN_W]);
  assign w_sat       = saturate(w_e_rnd, w_rnd[MAN_W-1:0]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_next = NORM;
      NORM:    if (w_norm_done) w_next = ROUND;
      ROUND:                    w_next = DONE;
      DONE:    if (out_ready)   w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh        <= '0;
      r_e         <= '0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
      r_s         <= 1'b0;
      r_eo        <= '0;
      r_f         <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_sign <= w_neg;
          r_sh   <= w_mag;
          r_e    <= E_INIT;
        end
        NORM: if (!w_norm_done) begin
          r_sh <= {r_sh[IN_W-2:0], 1'b0};
          r_e  <= r_e - CNT_W'(1);
        end
        ROUND: begin
          r_s         <= r_sign;
          r_eo        <= w_sat[EXP_W+MAN_W-1:MAN_W];
          r_f         <= w_sat[MAN_W-1:0];
          r_out_valid <= 1'b1;
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign E         = r_eo;
  assign F         = r_f;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Directed bench for int_to_float_seq: a signed default instance plus an
// unsigned instance, with hand-computed results and latencies.
module tb_int_to_float_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, S;
  logic [11:0] D;
  logic [2:0]  E;
  logic [3:0]  F;

  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_S;
  logic [11:0] u_D;
  logic [2:0]  u_E;
  logic [3:0]  u_F;

  int checks   = 0;
  int failures = 0;

  int_to_float_seq #(.IN_W(12), .EXP_W(3), .MAN_W(4), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .E(E), .F(F)
  );

  int_to_float_seq #(.IN_W(12), .EXP_W(3), .MAN_W(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready), .D(u_D),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .S(u_S), .E(u_E), .F(u_F)
  );

  // Drives one input, waits for out_valid and reports result, latency and
  // the number of cycles in_ready was wrongly high while busy.
  task automatic run_conv(input logic [11:0] d, output logic s, output logic [2:0] e,
                          output logic [3:0] f, output int lat, output int ir_bad);
    int guard;
    guard  = 0;
    ir_bad = 0;
    @(negedge clk);
    D = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    if (in_ready) ir_bad++;
    s = S; e = E; f = F;
  endtask

  task automatic handshake(output logic ov_after, output logic ir_after);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ov_after = out_valid;
    ir_after = in_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
    u_in_valid = 1'b0; u_out_ready = 1'b0; u_D = '0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, S, E, F} !== 9'b0) begin
      failures++; $display("FAIL reset_outputs got ov=%b S=%b E=%0d F=%b want all 0", out_valid, S, E, F);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || u_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b/%b want=1/1", in_ready, u_in_ready);
    end
  endtask

  task automatic test_backpressure;
    logic s, ov, ir;
    logic [2:0] e;
    logic [3:0] f;
    int lat, irb, bad;
    run_conv(12'h1A6, s, e, f, lat, irb);
    checks++;
    if ({s, e, f} !== {1'b0, 3'd5, 4'b1101}) begin
      failures++; $display("FAIL d422_value got S=%b E=%0d F=%b want S=0 E=5 F=1101", s, e, f);
    end
    checks++;
    if (lat !== 5) begin
      failures++; $display("FAIL d422_latency got=%0d want=5", lat);
    end
    checks++;
    if (irb !== 0) begin
      failures++; $display("FAIL d422_busy_ready got=%0d high cycles want=0", irb);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {S, E, F} !== {1'b0, 3'd5, 4'b1101}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL hold_stable got=%0d unstable cycles want=0", bad);
    end
    handshake(ov, ir);
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      failures++; $display("FAIL handshake_release got ov=%b ir=%b want ov=0 ir=1", ov, ir);
    end
    checks++;
    if ({S, E, F} !== {1'b0, 3'd5, 4'b1101}) begin
      failures++; $display("FAIL post_handshake_hold got S=%b E=%0d F=%b want S=0 E=5 F=1101", S, E, F);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] vd  [6] = '{12'h07D, 12'h800, 12'h7FF, 12'hFFF, 12'h000, 12'hFF1};
    logic [7:0]  vx  [6] = '{8'h48, 8'hFF, 8'h7F, 8'h81, 8'h00, 8'h8F};
    int          vl  [6] = '{7, 2, 3, 10, 10, 10};
    logic s, ov, ir;
    logic [2:0] e;
    logic [3:0] f;
    int lat, irb;
    for (int i = 0; i < 6; i++) begin
      run_conv(vd[i], s, e, f, lat, irb);
      checks++;
      if ({s, e, f} !== vx[i]) begin
        failures++;
        $display("FAIL b2b_value_%03h got S=%b E=%0d F=%b want S=%b E=%0d F=%b",
                 vd[i], s, e, f, vx[i][7], vx[i][6:4], vx[i][3:0]);
      end
      checks++;
      if (lat !== vl[i] || irb !== 0) begin
        failures++; $display("FAIL b2b_latency_%03h got=%0d busy_ready=%0d want=%0d busy_ready=0",
                             vd[i], lat, irb, vl[i]);
      end
      handshake(ov, ir);
    end
  endtask

  task automatic test_reset_mid;
    logic s, ov, ir;
    logic [2:0] e;
    logic [3:0] f;
    int lat, irb, bad;
    @(negedge clk);
    D = 12'h001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_in_ready got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0 || {S, E, F} !== 8'h00) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL midrst_discard got=%0d bad cycles want=0", bad);
    end
    run_conv(12'h010, s, e, f, lat, irb);
    checks++;
    if ({s, e, f} !== {1'b0, 3'd1, 4'b1000}) begin
      failures++; $display("FAIL midrst_next_value got S=%b E=%0d F=%b want S=0 E=1 F=1000", s, e, f);
    end
    checks++;
    if (lat !== 9) begin
      failures++; $display("FAIL midrst_next_latency got=%0d want=9", lat);
    end
    handshake(ov, ir);
  endtask

  task automatic test_unsigned;
    int lat;
    @(negedge clk);
    u_D = 12'hFFF;
    u_in_valid = 1'b1;
    @(posedge clk); #1;
    u_in_valid = 1'b0;
    lat = 0;
    while (!u_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({u_S, u_E, u_F} !== {1'b0, 3'd7, 4'b1111}) begin
      failures++; $display("FAIL unsigned_fff got S=%b E=%0d F=%b want S=0 E=7 F=1111", u_S, u_E, u_F);
    end
    checks++;
    if (lat !== 2) begin
      failures++; $display("FAIL unsigned_latency got=%0d want=2", lat);
    end
    @(negedge clk);
    u_out_ready = 1'b1;
    @(posedge clk); #1;
    u_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_unsigned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
